// File: rtl/shunt_fringe_payload_segmenter.sv
// ----------------------------------------------------------------------------
// shunt_fringe_payload_segmenter
//
// Put-side stage of the Fringe handshake framework. Captures one full signal
// value (bit and logic planes) together with its Signal DB index and size,
// then streams it out as consecutive PAYLOAD_BITS-wide payload words. Each
// request finishes with a one-cycle status report carrying the outcome and
// the per-signal event counter.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   put_valid / put_ready    request handshake
//   put_signal_index         Signal DB index of the request
//   put_signal_size          signal width in bits (1..MAX_BITS is legal)
//   put_data_bit/_logic      LSB-aligned bit and logic planes
//   pl_valid / pl_ready      payload word handshake
//   pl_data_bit/_logic       payload planes (bits beyond size forced to 0)
//   pl_signal_index          index of the signal being sent
//   pl_payload_num           0-based payload number within the signal
//   pl_last                  final payload of the signal
//   status_valid             one-cycle completion pulse
//   status_success           1 = all payloads sent, 0 = request rejected
//   status_signal_index      index of the completed request
//   status_event_cnt         that signal's event counter after the update
// ----------------------------------------------------------------------------
module shunt_fringe_payload_segmenter #(
    parameter int MAX_BITS     = 1024,
    parameter int PAYLOAD_BITS = 64,
    parameter int N_SIGNALS    = 8,
    parameter int IDX_W        = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    put_valid,
    output logic                    put_ready,
    input  logic [IDX_W-1:0]        put_signal_index,
    input  logic [31:0]             put_signal_size,
    input  logic [MAX_BITS-1:0]     put_data_bit,
    input  logic [MAX_BITS-1:0]     put_data_logic,
    output logic                    pl_valid,
    input  logic                    pl_ready,
    output logic [PAYLOAD_BITS-1:0] pl_data_bit,
    output logic [PAYLOAD_BITS-1:0] pl_data_logic,
    output logic [IDX_W-1:0]        pl_signal_index,
    output logic [4:0]              pl_payload_num,
    output logic                    pl_last,
    output logic                    status_valid,
    output logic                    status_success,
    output logic [IDX_W-1:0]        status_signal_index,
    output logic [63:0]             status_event_cnt
);

    localparam int N_WORDS = MAX_BITS / PAYLOAD_BITS;
    localparam int WSEL_W  = (N_WORDS > 1) ? $clog2(N_WORDS) : 1;
    localparam int CSEL_W  = (N_SIGNALS > 1) ? $clog2(N_SIGNALS) : 1;
    localparam int REM_W   = (PAYLOAD_BITS > 1) ? $clog2(PAYLOAD_BITS) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t state_q, state_d;

    // Captured request
    logic [MAX_BITS-1:0] data_bit_q;
    logic [MAX_BITS-1:0] data_logic_q;
    logic [IDX_W-1:0]    idx_q;
    logic [WSEL_W-1:0]   last_q;     // n-1, number of the final payload
    logic [REM_W-1:0]    rem_q;      // size mod PAYLOAD_BITS; 0 means last word is full
    logic [WSEL_W-1:0]   k_q;        // current payload number

    // Status report
    logic                stat_ok_q;
    logic [IDX_W-1:0]    stat_idx_q;
    logic [63:0]         stat_cnt_q;

    // Per-signal event counters
    logic [63:0]         cnt_q [N_SIGNALS];

    // ------------------------------------------------------------------------
    // Request decode
    // ------------------------------------------------------------------------
    logic accept;
    logic req_size_ok;
    logic req_idx_ok;
    logic req_ok;
    logic send_last_hs;

    assign accept       = put_valid && put_ready;
    assign req_size_ok  = (put_signal_size != 32'd0) && (put_signal_size <= 32'(MAX_BITS));
    assign req_idx_ok   = (put_signal_index < IDX_W'(N_SIGNALS));
    assign req_ok       = req_size_ok && req_idx_ok;
    // Final handshake of a successful send: bumps the counter and reports it.
    assign send_last_hs = (state_q == ST_SEND) && pl_ready && (k_q == last_q);

    // ------------------------------------------------------------------------
    // Payload word selection and tail masking
    // ------------------------------------------------------------------------
    logic [PAYLOAD_BITS-1:0] words_bit   [N_WORDS];
    logic [PAYLOAD_BITS-1:0] words_logic [N_WORDS];
    logic [PAYLOAD_BITS-1:0] keep;

    for (genvar gi = 0; gi < N_WORDS; gi++) begin : g_words
        assign words_bit[gi]   = data_bit_q[gi*PAYLOAD_BITS +: PAYLOAD_BITS];
        assign words_logic[gi] = data_logic_q[gi*PAYLOAD_BITS +: PAYLOAD_BITS];
    end

    // A bit survives unless this is the last word, the signal ends inside it,
    // and the bit lies at or beyond the signal's end.
    for (genvar gi = 0; gi < PAYLOAD_BITS; gi++) begin : g_keep
        assign keep[gi] = (k_q != last_q) || (rem_q == '0) || (REM_W'(gi) < rem_q);
    end

    // ------------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = req_ok ? ST_SEND : ST_DONE;
                end
            end
            ST_SEND: begin
                if (send_last_hs) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // FSM: outputs (everything gated by state so reset forces idle values)
    // ------------------------------------------------------------------------
    always_comb begin
        put_ready           = 1'b0;
        pl_valid            = 1'b0;
        pl_data_bit         = '0;
        pl_data_logic       = '0;
        pl_signal_index     = '0;
        pl_payload_num      = '0;
        pl_last             = 1'b0;
        status_valid        = 1'b0;
        status_success      = 1'b0;
        status_signal_index = '0;
        status_event_cnt    = '0;
        unique case (state_q)
            ST_IDLE: begin
                put_ready = !rst;
            end
            ST_SEND: begin
                pl_valid        = 1'b1;
                pl_data_bit     = words_bit[k_q] & keep;
                pl_data_logic   = words_logic[k_q] & keep;
                pl_signal_index = idx_q;
                pl_payload_num  = 5'(k_q);
                pl_last         = (k_q == last_q);
            end
            ST_DONE: begin
                status_valid        = 1'b1;
                status_success      = stat_ok_q;
                status_signal_index = stat_idx_q;
                status_event_cnt    = stat_cnt_q;
            end
            default: begin
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Data capture (outputs are gated by state, so no reset is needed here)
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (accept) begin
            data_bit_q   <= put_data_bit;
            data_logic_q <= put_data_logic;
        end
    end

    // ------------------------------------------------------------------------
    // Control registers, status and counters
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q      <= '0;
            last_q     <= '0;
            rem_q      <= '0;
            k_q        <= '0;
            stat_ok_q  <= 1'b0;
            stat_idx_q <= '0;
            stat_cnt_q <= '0;
            for (int i = 0; i < N_SIGNALS; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            if (accept) begin
                idx_q      <= put_signal_index;
                last_q     <= WSEL_W'((put_signal_size - 32'd1) / 32'(PAYLOAD_BITS));
                rem_q      <= REM_W'(put_signal_size % 32'(PAYLOAD_BITS));
                k_q        <= '0;
                stat_idx_q <= put_signal_index;
                // Rejections report here; successes overwrite at the last handshake.
                stat_ok_q  <= 1'b0;
                stat_cnt_q <= req_idx_ok ? cnt_q[put_signal_index[CSEL_W-1:0]] : 64'd0;
            end
            if ((state_q == ST_SEND) && pl_ready && (k_q != last_q)) begin
                k_q <= k_q + 1'b1;
            end
            if (send_last_hs) begin
                cnt_q[idx_q[CSEL_W-1:0]] <= cnt_q[idx_q[CSEL_W-1:0]] + 64'd1;
                stat_ok_q  <= 1'b1;
                stat_cnt_q <= cnt_q[idx_q[CSEL_W-1:0]] + 64'd1;
            end
        end
    end

endmodule

// File: tb/tb_shunt_fringe_payload_segmenter.sv
// ----------------------------------------------------------------------------
// Directed testbench for shunt_fringe_payload_segmenter. Inputs are driven and
// outputs sampled on the falling clock edge.
// ----------------------------------------------------------------------------
module tb_shunt_fringe_payload_segmenter;

    logic          clk;
    logic          rst;
    logic          put_valid;
    logic          put_ready;
    logic [31:0]   put_signal_index;
    logic [31:0]   put_signal_size;
    logic [1023:0] put_data_bit;
    logic [1023:0] put_data_logic;
    logic          pl_valid;
    logic          pl_ready;
    logic [63:0]   pl_data_bit;
    logic [63:0]   pl_data_logic;
    logic [31:0]   pl_signal_index;
    logic [4:0]    pl_payload_num;
    logic          pl_last;
    logic          status_valid;
    logic          status_success;
    logic [31:0]   status_signal_index;
    logic [63:0]   status_event_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    shunt_fringe_payload_segmenter #(
        .MAX_BITS    (1024),
        .PAYLOAD_BITS(64),
        .N_SIGNALS   (8),
        .IDX_W       (32)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .put_valid          (put_valid),
        .put_ready          (put_ready),
        .put_signal_index   (put_signal_index),
        .put_signal_size    (put_signal_size),
        .put_data_bit       (put_data_bit),
        .put_data_logic     (put_data_logic),
        .pl_valid           (pl_valid),
        .pl_ready           (pl_ready),
        .pl_data_bit        (pl_data_bit),
        .pl_data_logic      (pl_data_logic),
        .pl_signal_index    (pl_signal_index),
        .pl_payload_num     (pl_payload_num),
        .pl_last            (pl_last),
        .status_valid       (status_valid),
        .status_success     (status_success),
        .status_signal_index(status_signal_index),
        .status_event_cnt   (status_event_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%h, expected 0x%h", tag, obs, exp);
        end
    endtask

    // Expected payload word k: input bit at absolute position p if p < size, else 0.
    function automatic logic [63:0] exp_word(input logic [1023:0] d, input int size, input int k);
        logic [63:0] w;
        int pos;
        w = '0;
        for (int j = 0; j < 64; j++) begin
            pos = k * 64 + j;
            w[j] = (pos < size) ? d[pos] : 1'b0;
        end
        return w;
    endfunction

    // One complete put transaction. bp selects the 1,0,0,1 pl_ready pattern.
    task automatic run_put(input int idx, input int size,
                           input logic [1023:0] db, input logic [1023:0] dl,
                           input bit bp, input bit exp_ok, input logic [63:0] exp_cnt);
        int n;
        int hs;
        int stalls;
        int sendc;
        int cyc;
        bit done;
        n = exp_ok ? (size + 63) / 64 : 0;
        put_valid        = 1'b1;
        put_signal_index = idx;
        put_signal_size  = size;
        put_data_bit     = db;
        put_data_logic   = dl;
        pl_ready         = 1'b1;
        check("put_ready_idle", {63'd0, put_ready}, 64'd1);
        @(negedge clk);
        // Scramble the inputs so only the captured copy can produce correct data.
        put_valid      = 1'b0;
        put_data_bit   = ~db;
        put_data_logic = ~dl;
        hs = 0; stalls = 0; sendc = 0; cyc = 1; done = 1'b0;
        while (!done && cyc <= 100) begin
            check("put_ready_busy", {63'd0, put_ready}, 64'd0);
            if (status_valid) begin
                check("status_success", {63'd0, status_success}, {63'd0, exp_ok});
                check("status_index", {32'd0, status_signal_index}, 64'(idx));
                check("status_cnt", status_event_cnt, exp_cnt);
                check("status_cycle", 64'(cyc), 64'(n + stalls + 1));
                check("payload_count", 64'(hs), 64'(n));
                check("pl_valid_in_done", {63'd0, pl_valid}, 64'd0);
                done = 1'b1;
            end else if (pl_valid) begin
                if (!exp_ok) begin
                    check("err_pl_valid", 64'd1, 64'd0);
                end
                check("pl_data_bit", pl_data_bit, exp_word(db, size, hs));
                check("pl_data_logic", pl_data_logic, exp_word(dl, size, hs));
                check("pl_payload_num", {59'd0, pl_payload_num}, 64'(hs));
                check("pl_last", {63'd0, pl_last}, (hs == n - 1) ? 64'd1 : 64'd0);
                check("pl_index", {32'd0, pl_signal_index}, 64'(idx));
                pl_ready = bp ? ((sendc % 4 == 0) || (sendc % 4 == 3)) : 1'b1;
                sendc++;
                if (pl_ready) hs++;
                else stalls++;
            end else begin
                check("busy_no_activity", 64'd0, 64'd1);
            end
            if (!done) begin
                @(negedge clk);
                cyc++;
            end
        end
        if (!done) begin
            check("status_timeout", 64'd0, 64'd1);
        end
        @(negedge clk);
        check("put_ready_after", {63'd0, put_ready}, 64'd1);
        check("status_one_cycle", {63'd0, status_valid}, 64'd0);
        $display("[TB] put idx=%0d size=%0d payloads=%0d stalls=%0d exp_ok=%0b exp_cnt=%0d",
                 idx, size, hs, stalls, exp_ok, exp_cnt);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_pl_valid"}, {63'd0, pl_valid}, 64'd0);
        check({tag, "_pl_last"}, {63'd0, pl_last}, 64'd0);
        check({tag, "_pl_num"}, {59'd0, pl_payload_num}, 64'd0);
        check({tag, "_pl_bit"}, pl_data_bit, 64'd0);
        check({tag, "_pl_logic"}, pl_data_logic, 64'd0);
        check({tag, "_pl_index"}, {32'd0, pl_signal_index}, 64'd0);
        check({tag, "_st_valid"}, {63'd0, status_valid}, 64'd0);
        check({tag, "_st_success"}, {63'd0, status_success}, 64'd0);
        check({tag, "_st_index"}, {32'd0, status_signal_index}, 64'd0);
        check({tag, "_st_cnt"}, status_event_cnt, 64'd0);
    endtask

    logic [1023:0] d_a;
    logic [1023:0] d_b;
    logic [1023:0] ones;

    initial begin
        rst              = 1'b1;
        put_valid        = 1'b0;
        put_signal_index = '0;
        put_signal_size  = '0;
        put_data_bit     = '0;
        put_data_logic   = '0;
        pl_ready         = 1'b0;
        ones             = '1;

        // Reset state
        repeat (3) @(negedge clk);
        check("reset_put_ready", {63'd0, put_ready}, 64'd0);
        check_idle_outputs("reset");
        rst = 1'b0;
        @(negedge clk);
        check("post_reset_put_ready", {63'd0, put_ready}, 64'd1);
        $display("[TB] reset released");

        // Single-payload put
        d_a = '0; d_a[63:0] = 64'hDEADBEEF_CAFEF00D;
        d_b = '0; d_b[63:0] = 64'h01234567_89ABCDEF;
        run_put(2, 64, d_a, d_b, 1'b0, 1'b1, 64'd1);

        // Partial last word: payload 2 must read 0x3 in both planes
        run_put(0, 130, ones, ones, 1'b0, 1'b1, 64'd1);

        // Backpressure with distinct words
        for (int k = 0; k < 16; k++) begin
            d_a[k*64 +: 64] = {32'hB0B0_0000 | 32'(k), 32'h1234_0000 | 32'(k)};
            d_b[k*64 +: 64] = ~{32'hB0B0_0000 | 32'(k), 32'h1234_0000 | 32'(k)};
        end
        run_put(4, 256, d_a, d_b, 1'b1, 1'b1, 64'd1);

        // Rejected requests
        run_put(0, 0, d_a, d_b, 1'b0, 1'b0, 64'd1);
        run_put(4, 1025, d_a, d_b, 1'b0, 1'b0, 64'd1);
        run_put(8, 64, d_a, d_b, 1'b0, 1'b0, 64'd0);

        // Counters, minimum size and index 0 unchanged by the rejection
        run_put(0, 1, ones, ones, 1'b0, 1'b1, 64'd2);
        run_put(1, 100, d_a, d_b, 1'b0, 1'b1, 64'd1);
        run_put(1, 64, d_a, d_b, 1'b0, 1'b1, 64'd2);
        run_put(1, 65, d_a, d_b, 1'b0, 1'b1, 64'd3);
        run_put(5, 8, d_a, d_b, 1'b0, 1'b1, 64'd1);

        // Maximum size
        run_put(6, 1024, d_a, d_b, 1'b0, 1'b1, 64'd1);

        // Reset during payload 1 of a 4-payload put to index 2
        put_valid        = 1'b1;
        put_signal_index = 2;
        put_signal_size  = 256;
        put_data_bit     = d_a;
        put_data_logic   = d_b;
        pl_ready         = 1'b1;
        @(negedge clk);
        put_valid = 1'b0;
        check("midrst_pl0", {59'd0, pl_payload_num}, 64'd0);
        @(negedge clk);
        check("midrst_pl1", {59'd0, pl_payload_num}, 64'd1);
        check("midrst_pl1_valid", {63'd0, pl_valid}, 64'd1);
        rst      = 1'b1;
        pl_ready = 1'b0;
        @(negedge clk);
        check("midrst_put_ready", {63'd0, put_ready}, 64'd0);
        check_idle_outputs("midrst");
        rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("midrst_no_status", {63'd0, status_valid}, 64'd0);
            check("midrst_no_pl", {63'd0, pl_valid}, 64'd0);
        end
        $display("[TB] reset during send done");
        run_put(2, 64, d_a, d_b, 1'b0, 1'b1, 64'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
